// File: rtl/binary_bbox_tracker.sv
// Binary foreground bounding-box tracker on an Avalon-ST pixel stream.
// One-deep registered pass-through with optional overlay of the previous frame's box perimeter.
module binary_bbox_tracker #(
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter bit          OVERLAY_EN     = 1'b1,
    parameter logic [29:0] OVERLAY_COLOUR = 30'h3FF00000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [29:0]                          data_i,
    input  logic                                 startofpacket_i,
    input  logic                                 endofpacket_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic [29:0]                          data_o,
    output logic                                 startofpacket_o,
    output logic                                 endofpacket_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [$clog2(WIDTH)-1:0]             bbox_min_x,
    output logic [$clog2(WIDTH)-1:0]             bbox_max_x,
    output logic [$clog2(HEIGHT)-1:0]            bbox_min_y,
    output logic [$clog2(HEIGHT)-1:0]            bbox_max_y,
    output logic [$clog2(WIDTH*HEIGHT):0]        fg_count,
    output logic                                 bbox_valid,
    output logic                                 frame_done
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned CW = $clog2(WIDTH * HEIGHT) + 1;
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic          valid_q, sop_q, eop_q;
    logic [29:0]   data_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic          found_q, found_d;
    logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [XW-1:0] res_min_x_q, res_min_x_d, res_max_x_q, res_max_x_d;
    logic [YW-1:0] res_min_y_q, res_min_y_d, res_max_y_q, res_max_y_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic          res_valid_q, res_valid_d;
    logic          done_q, done_d;

    logic          accept;
    logic          fg;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          in_x, in_y, on_x, on_y, hit;
    logic [29:0]   pix;

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;
    assign fg      = data_i[29];

    // A sop beat always sits at the origin, whatever the counters say.
    assign cur_x = startofpacket_i ? '0 : x_q;
    assign cur_y = startofpacket_i ? '0 : y_q;

    assign in_x = (cur_x >= res_min_x_q) && (cur_x <= res_max_x_q);
    assign in_y = (cur_y >= res_min_y_q) && (cur_y <= res_max_y_q);
    assign on_x = (cur_x == res_min_x_q) || (cur_x == res_max_x_q);
    assign on_y = (cur_y == res_min_y_q) || (cur_y == res_max_y_q);
    assign hit  = (in_x & on_y) | (in_y & on_x);
    assign pix  = (OVERLAY_EN && enable && res_valid_q && hit) ? OVERLAY_COLOUR : data_i;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sop_q   <= startofpacket_i;
            eop_q   <= endofpacket_i;
            data_q  <= pix;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Raster coordinate of the next beat; y saturates on overlong frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (cur_x == XMAX) begin
                x_q <= '0;
                y_q <= (cur_y == YMAX) ? cur_y : cur_y + YW'(1);
            end else begin
                x_q <= cur_x + XW'(1);
                y_q <= cur_y;
            end
        end
    end

    logic          acc_found;
    logic [XW-1:0] acc_min_x, acc_max_x;
    logic [YW-1:0] acc_min_y, acc_max_y;
    logic [CW-1:0] acc_cnt;

    always_comb begin
        state_d     = state_q;
        found_d     = found_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        min_y_d     = min_y_q;
        max_y_d     = max_y_q;
        cnt_d       = cnt_q;
        res_min_x_d = res_min_x_q;
        res_max_x_d = res_max_x_q;
        res_min_y_d = res_min_y_q;
        res_max_y_d = res_max_y_q;
        res_cnt_d   = res_cnt_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;

        // A sop beat starts from empty accumulators, discarding any partial frame.
        acc_found = startofpacket_i ? 1'b0 : found_q;
        acc_cnt   = startofpacket_i ? '0 : cnt_q;
        acc_min_x = min_x_q;
        acc_max_x = max_x_q;
        acc_min_y = min_y_q;
        acc_max_y = max_y_q;

        if (fg) begin
            if (!acc_found) begin
                acc_min_x = cur_x;
                acc_max_x = cur_x;
                acc_min_y = cur_y;
                acc_max_y = cur_y;
            end else begin
                if (cur_x < acc_min_x) acc_min_x = cur_x;
                if (cur_x > acc_max_x) acc_max_x = cur_x;
                if (cur_y < acc_min_y) acc_min_y = cur_y;
                if (cur_y > acc_max_y) acc_max_y = cur_y;
            end
            acc_found = 1'b1;
            acc_cnt   = acc_cnt + CW'(1);
        end

        if (!enable) begin
            state_d = StIdle;
            found_d = 1'b0;
            cnt_d   = '0;
        end else if (accept && (startofpacket_i || state_q == StActive)) begin
            if (endofpacket_i) begin
                state_d     = StIdle;
                found_d     = 1'b0;
                cnt_d       = '0;
                done_d      = 1'b1;
                res_cnt_d   = acc_cnt;
                res_valid_d = acc_found;
                if (acc_found) begin
                    res_min_x_d = acc_min_x;
                    res_max_x_d = acc_max_x;
                    res_min_y_d = acc_min_y;
                    res_max_y_d = acc_max_y;
                end
            end else begin
                state_d = StActive;
                found_d = acc_found;
                cnt_d   = acc_cnt;
                min_x_d = acc_min_x;
                max_x_d = acc_max_x;
                min_y_d = acc_min_y;
                max_y_d = acc_max_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            found_q     <= 1'b0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            min_y_q     <= '0;
            max_y_q     <= '0;
            cnt_q       <= '0;
            res_min_x_q <= '0;
            res_max_x_q <= '0;
            res_min_y_q <= '0;
            res_max_y_q <= '0;
            res_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            found_q     <= found_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            min_y_q     <= min_y_d;
            max_y_q     <= max_y_d;
            cnt_q       <= cnt_d;
            res_min_x_q <= res_min_x_d;
            res_max_x_q <= res_max_x_d;
            res_min_y_q <= res_min_y_d;
            res_max_y_q <= res_max_y_d;
            res_cnt_q   <= res_cnt_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign valid_o         = valid_q;
    assign startofpacket_o = sop_q;
    assign endofpacket_o   = eop_q;
    assign data_o          = data_q;
    assign bbox_min_x      = res_min_x_q;
    assign bbox_max_x      = res_max_x_q;
    assign bbox_min_y      = res_min_y_q;
    assign bbox_max_y      = res_max_y_q;
    assign fg_count        = res_cnt_q;
    assign bbox_valid      = res_valid_q;
    assign frame_done      = done_q;

endmodule
